// File: rtl/decode_stage_if.sv
// Decode stage bus: fetch offer, GRF/CSR read ports and the decoded bundle toward execute.
// slave = decode stage, master = surrounding pipeline driving the i_* side.
interface decode_stage_if #(
    parameter int unsigned XLEN = 64
);
    logic            i_Flush;
    logic            i_Valid;
    logic            o_Ready;
    logic [XLEN-1:0] i_PC;
    logic [31:0]     i_Inst_32;
    logic [4:0]      o_GRFReadAddr1_5;
    logic [4:0]      o_GRFReadAddr2_5;
    logic [XLEN-1:0] i_GRFReadData1;
    logic [XLEN-1:0] i_GRFReadData2;
    logic [11:0]     o_CSRReadAddr_12;
    logic [XLEN-1:0] i_CSRReadData;
    logic            o_Valid;
    logic            i_Ready;
    logic [XLEN-1:0] o_PC;
    logic [XLEN-1:0] o_Rs1Data;
    logic [XLEN-1:0] o_Rs2Data;
    logic [XLEN-1:0] o_CSRData;
    logic [XLEN-1:0] o_Imm;
    logic [4:0]      o_Rd_5;
    logic            o_RegWrite;
    logic [3:0]      o_AluOp_4;
    logic            o_SrcA_PC;
    logic            o_SrcB_Imm;
    logic            o_MemRead;
    logic            o_MemWrite;
    logic [1:0]      o_MemSize_2;
    logic            o_MemUnsigned;
    logic            o_Branch;
    logic [2:0]      o_BrCond_3;
    logic            o_Jump;
    logic            o_IsJalr;
    logic            o_WordOp;
    logic            o_Csr;
    logic            o_Ecall;
    logic            o_Ebreak;
    logic            o_Illegal;

    modport slave (
        input  i_Flush, i_Valid, i_PC, i_Inst_32, i_GRFReadData1, i_GRFReadData2,
               i_CSRReadData, i_Ready,
        output o_Ready, o_GRFReadAddr1_5, o_GRFReadAddr2_5, o_CSRReadAddr_12, o_Valid,
               o_PC, o_Rs1Data, o_Rs2Data, o_CSRData, o_Imm, o_Rd_5, o_RegWrite, o_AluOp_4,
               o_SrcA_PC, o_SrcB_Imm, o_MemRead, o_MemWrite, o_MemSize_2, o_MemUnsigned,
               o_Branch, o_BrCond_3, o_Jump, o_IsJalr, o_WordOp, o_Csr, o_Ecall, o_Ebreak,
               o_Illegal
    );

    modport master (
        output i_Flush, i_Valid, i_PC, i_Inst_32, i_GRFReadData1, i_GRFReadData2,
               i_CSRReadData, i_Ready,
        input  o_Ready, o_GRFReadAddr1_5, o_GRFReadAddr2_5, o_CSRReadAddr_12, o_Valid,
               o_PC, o_Rs1Data, o_Rs2Data, o_CSRData, o_Imm, o_Rd_5, o_RegWrite, o_AluOp_4,
               o_SrcA_PC, o_SrcB_Imm, o_MemRead, o_MemWrite, o_MemSize_2, o_MemUnsigned,
               o_Branch, o_BrCond_3, o_Jump, o_IsJalr, o_WordOp, o_Csr, o_Ecall, o_Ebreak,
               o_Illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: one instruction per cycle, registered bundle toward execute,
// valid/ready handshake with back-pressure and redirect flush.
module decode_stage #(
    parameter int unsigned XLEN        = 64,
    parameter bit          EN_WORD_OPS = 1'b1
) (
    input  logic          i_Clk,
    input  logic          i_Rst_n,
    decode_stage_if.slave io_Dec
);
    localparam bit RV64    = (XLEN == 64);
    localparam bit WORD_OK = RV64 && EN_WORD_OPS;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            reg_write;
        logic [3:0]      alu_op;
        logic            src_a_pc;
        logic            src_b_imm;
        logic            mem_read;
        logic            mem_write;
        logic [1:0]      mem_size;
        logic            mem_unsigned;
        logic            branch;
        logic [2:0]      br_cond;
        logic            jump;
        logic            is_jalr;
        logic            word_op;
        logic            csr;
        logic            ecall;
        logic            ebreak;
        logic            illegal;
    } ctrl_t;

    // inst[30] selects SUB (register form only) or SRA
    function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt,
                                          input logic allow_sub);
        case (f3)
            3'd0:    alu_of = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
            3'd1:    alu_of = ALU_SLL;
            3'd2:    alu_of = ALU_SLT;
            3'd3:    alu_of = ALU_SLTU;
            3'd4:    alu_of = ALU_XOR;
            3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
            3'd6:    alu_of = ALU_OR;
            default: alu_of = ALU_AND;
        endcase
    endfunction

    logic [31:0]        w_inst;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic signed [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
    logic [XLEN-1:0]    w_sx_i, w_sx_s, w_sx_b, w_sx_u, w_sx_j;
    ctrl_t              w_dec;
    logic               w_ill;
    logic               w_ready;
    logic               w_accept;

    logic               r_Valid;
    logic [XLEN-1:0]    r_PC, r_Rs1, r_Rs2, r_CSR;
    logic [4:0]         r_Rd;
    ctrl_t              r_Ctrl;

    assign w_inst  = io_Dec.i_Inst_32;
    assign w_f3    = w_inst[14:12];
    assign w_f7    = w_inst[31:25];
    assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
    assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
    assign w_imm_b = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
    assign w_imm_u = {w_inst[31:12], 12'b0};
    assign w_imm_j = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
    assign w_sx_i  = XLEN'(w_imm_i);
    assign w_sx_s  = XLEN'(w_imm_s);
    assign w_sx_b  = XLEN'(w_imm_b);
    assign w_sx_u  = XLEN'(w_imm_u);
    assign w_sx_j  = XLEN'(w_imm_j);

    // Field split and legality; an illegal instruction collapses to a bare illegal flag
    always_comb begin
        w_dec = '0;
        w_ill = 1'b0;
        case (w_inst[6:0])
            OPC_LUI: begin
                w_dec.imm = w_sx_u; w_dec.alu_op = ALU_PASSB;
                w_dec.src_b_imm = 1'b1; w_dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                w_dec.imm = w_sx_u; w_dec.src_a_pc = 1'b1;
                w_dec.src_b_imm = 1'b1; w_dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                w_dec.imm = w_sx_j; w_dec.src_a_pc = 1'b1; w_dec.src_b_imm = 1'b1;
                w_dec.jump = 1'b1; w_dec.reg_write = 1'b1;
            end
            OPC_JALR: begin
                w_dec.imm = w_sx_i; w_dec.src_a_pc = 1'b1; w_dec.src_b_imm = 1'b1;
                w_dec.jump = 1'b1; w_dec.is_jalr = 1'b1; w_dec.reg_write = 1'b1;
                w_ill = (w_f3 != 3'd0);
            end
            OPC_BRANCH: begin
                w_dec.imm = w_sx_b; w_dec.branch = 1'b1; w_dec.br_cond = w_f3;
                w_ill = (w_f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                w_dec.imm = w_sx_i; w_dec.src_b_imm = 1'b1; w_dec.mem_read = 1'b1;
                w_dec.reg_write = 1'b1; w_dec.mem_size = w_f3[1:0];
                w_dec.mem_unsigned = w_f3[2];
                w_ill = (w_f3 == 3'd7) || (!RV64 && (w_f3 == 3'd3 || w_f3 == 3'd6));
            end
            OPC_STORE: begin
                w_dec.imm = w_sx_s; w_dec.src_b_imm = 1'b1; w_dec.mem_write = 1'b1;
                w_dec.mem_size = w_f3[1:0];
                w_ill = w_f3[2] || (!RV64 && w_f3 == 3'd3);
            end
            OPC_OPIMM: begin
                w_dec.imm = w_sx_i; w_dec.src_b_imm = 1'b1; w_dec.reg_write = 1'b1;
                w_dec.alu_op = alu_of(w_f3, w_inst[30], 1'b0);
                if (w_f3 == 3'd1)
                    w_ill = (w_inst[31:26] != 6'd0) || (!RV64 && w_inst[25]);
                else if (w_f3 == 3'd5)
                    w_ill = ({w_inst[31], w_inst[29:26]} != 5'd0) || (!RV64 && w_inst[25]);
            end
            OPC_OP: begin
                w_dec.reg_write = 1'b1;
                w_dec.alu_op = alu_of(w_f3, w_inst[30], 1'b1);
                w_ill = !((w_f7 == 7'h00) ||
                          (w_f7 == 7'h20 && (w_f3 == 3'd0 || w_f3 == 3'd5)));
            end
            OPC_OPIMMW: begin
                w_dec.imm = w_sx_i; w_dec.src_b_imm = 1'b1; w_dec.reg_write = 1'b1;
                w_dec.word_op = 1'b1; w_dec.alu_op = alu_of(w_f3, w_inst[30], 1'b0);
                w_ill = !WORD_OK ||
                        !((w_f3 == 3'd0) ||
                          (w_f3 == 3'd1 && w_f7 == 7'h00) ||
                          (w_f3 == 3'd5 && (w_f7 == 7'h00 || w_f7 == 7'h20)));
            end
            OPC_OPW: begin
                w_dec.reg_write = 1'b1; w_dec.word_op = 1'b1;
                w_dec.alu_op = alu_of(w_f3, w_inst[30], 1'b1);
                w_ill = !WORD_OK ||
                        !((w_f3 == 3'd0 && (w_f7 == 7'h00 || w_f7 == 7'h20)) ||
                          (w_f3 == 3'd1 && w_f7 == 7'h00) ||
                          (w_f3 == 3'd5 && (w_f7 == 7'h00 || w_f7 == 7'h20)));
            end
            OPC_MISC: begin
                w_dec.imm = w_sx_i;
                w_ill = (w_f3 != 3'd0);
            end
            OPC_SYSTEM: begin
                w_dec.imm = w_sx_i;
                if (w_f3 == 3'd0) begin
                    w_dec.ecall  = (w_inst == 32'h0000_0073);
                    w_dec.ebreak = (w_inst == 32'h0010_0073);
                    w_ill = !(w_dec.ecall || w_dec.ebreak);
                end else if (w_f3 == 3'd4) begin
                    w_ill = 1'b1;
                end else begin
                    w_dec.csr = 1'b1; w_dec.reg_write = 1'b1; w_dec.br_cond = w_f3;
                end
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_dec         = '0;
            w_dec.illegal = 1'b1;
        end else if (w_inst[11:7] == 5'd0) begin
            w_dec.reg_write = 1'b0;
        end
    end

    assign w_ready  = !r_Valid || io_Dec.i_Ready;
    assign w_accept = io_Dec.i_Valid && w_ready && !io_Dec.i_Flush;

    // Flush beats accept and stall; a stalled bundle holds every register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_Valid <= 1'b0;
            r_PC    <= '0;
            r_Rs1   <= '0;
            r_Rs2   <= '0;
            r_CSR   <= '0;
            r_Rd    <= '0;
            r_Ctrl  <= '0;
        end else if (io_Dec.i_Flush) begin
            r_Valid <= 1'b0;
        end else if (w_accept) begin
            r_Valid <= 1'b1;
            r_PC    <= io_Dec.i_PC;
            r_Rs1   <= io_Dec.i_GRFReadData1;
            r_Rs2   <= io_Dec.i_GRFReadData2;
            r_CSR   <= io_Dec.i_CSRReadData;
            r_Rd    <= w_inst[11:7];
            r_Ctrl  <= w_dec;
        end else if (io_Dec.i_Ready) begin
            r_Valid <= 1'b0;
        end
    end

    assign io_Dec.o_Ready          = w_ready;
    assign io_Dec.o_GRFReadAddr1_5 = w_inst[19:15];
    assign io_Dec.o_GRFReadAddr2_5 = w_inst[24:20];
    assign io_Dec.o_CSRReadAddr_12 = w_inst[31:20];
    assign io_Dec.o_Valid          = r_Valid;
    assign io_Dec.o_PC             = r_PC;
    assign io_Dec.o_Rs1Data        = r_Rs1;
    assign io_Dec.o_Rs2Data        = r_Rs2;
    assign io_Dec.o_CSRData        = r_CSR;
    assign io_Dec.o_Imm            = r_Ctrl.imm;
    assign io_Dec.o_Rd_5           = r_Rd;
    assign io_Dec.o_RegWrite       = r_Ctrl.reg_write;
    assign io_Dec.o_AluOp_4        = r_Ctrl.alu_op;
    assign io_Dec.o_SrcA_PC        = r_Ctrl.src_a_pc;
    assign io_Dec.o_SrcB_Imm       = r_Ctrl.src_b_imm;
    assign io_Dec.o_MemRead        = r_Ctrl.mem_read;
    assign io_Dec.o_MemWrite       = r_Ctrl.mem_write;
    assign io_Dec.o_MemSize_2      = r_Ctrl.mem_size;
    assign io_Dec.o_MemUnsigned    = r_Ctrl.mem_unsigned;
    assign io_Dec.o_Branch         = r_Ctrl.branch;
    assign io_Dec.o_BrCond_3       = r_Ctrl.br_cond;
    assign io_Dec.o_Jump           = r_Ctrl.jump;
    assign io_Dec.o_IsJalr         = r_Ctrl.is_jalr;
    assign io_Dec.o_WordOp         = r_Ctrl.word_op;
    assign io_Dec.o_Csr            = r_Ctrl.csr;
    assign io_Dec.o_Ecall          = r_Ctrl.ecall;
    assign io_Dec.o_Ebreak         = r_Ctrl.ebreak;
    assign io_Dec.o_Illegal        = r_Ctrl.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: three configurations (RV64, RV32, RV64 without *W ops) share one
// stimulus stream and are checked every cycle against an instruction-level reference model.
module tb_decode_stage;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_valid = 1'b0, s_ready = 1'b0, s_flush = 1'b0;
    logic [31:0] s_inst  = '0;
    logic [63:0] s_pc = '0, s_rs1 = '0, s_rs2 = '0, s_csr = '0;

    int n_cmp = 0;
    int n_bad = 0;

    decode_stage_if #(.XLEN(64)) if64 ();
    decode_stage_if #(.XLEN(32)) if32 ();
    decode_stage_if #(.XLEN(64)) ifnw ();

    decode_stage #(.XLEN(64), .EN_WORD_OPS(1'b1)) u_d64 (.i_Clk(clk), .i_Rst_n(rst_n), .io_Dec(if64));
    decode_stage #(.XLEN(32), .EN_WORD_OPS(1'b1)) u_d32 (.i_Clk(clk), .i_Rst_n(rst_n), .io_Dec(if32));
    decode_stage #(.XLEN(64), .EN_WORD_OPS(1'b0)) u_dnw (.i_Clk(clk), .i_Rst_n(rst_n), .io_Dec(ifnw));

    assign if64.i_Flush = s_flush;  assign if32.i_Flush = s_flush;  assign ifnw.i_Flush = s_flush;
    assign if64.i_Valid = s_valid;  assign if32.i_Valid = s_valid;  assign ifnw.i_Valid = s_valid;
    assign if64.i_Ready = s_ready;  assign if32.i_Ready = s_ready;  assign ifnw.i_Ready = s_ready;
    assign if64.i_Inst_32 = s_inst; assign if32.i_Inst_32 = s_inst; assign ifnw.i_Inst_32 = s_inst;
    assign if64.i_PC = s_pc;        assign if32.i_PC = s_pc[31:0];  assign ifnw.i_PC = s_pc;
    assign if64.i_GRFReadData1 = s_rs1; assign if32.i_GRFReadData1 = s_rs1[31:0]; assign ifnw.i_GRFReadData1 = s_rs1;
    assign if64.i_GRFReadData2 = s_rs2; assign if32.i_GRFReadData2 = s_rs2[31:0]; assign ifnw.i_GRFReadData2 = s_rs2;
    assign if64.i_CSRReadData = s_csr;  assign if32.i_CSRReadData = s_csr[31:0];  assign ifnw.i_CSRReadData = s_csr;

    // Observed outputs of the three instances, widened to 64 bits; control flags packed
    logic [22:0] a_ctrl [3];
    logic [63:0] a_imm [3], a_pc [3], a_r1 [3], a_r2 [3], a_cd [3];
    logic [4:0]  a_rd [3], a_ad1 [3], a_ad2 [3];
    logic [11:0] a_cad [3];
    logic        a_v [3], a_rdy [3];

    assign a_ctrl[0] = {if64.o_RegWrite, if64.o_AluOp_4, if64.o_SrcA_PC, if64.o_SrcB_Imm,
                        if64.o_MemRead, if64.o_MemWrite, if64.o_MemSize_2, if64.o_MemUnsigned,
                        if64.o_Branch, if64.o_BrCond_3, if64.o_Jump, if64.o_IsJalr, if64.o_WordOp,
                        if64.o_Csr, if64.o_Ecall, if64.o_Ebreak, if64.o_Illegal};
    assign a_ctrl[1] = {if32.o_RegWrite, if32.o_AluOp_4, if32.o_SrcA_PC, if32.o_SrcB_Imm,
                        if32.o_MemRead, if32.o_MemWrite, if32.o_MemSize_2, if32.o_MemUnsigned,
                        if32.o_Branch, if32.o_BrCond_3, if32.o_Jump, if32.o_IsJalr, if32.o_WordOp,
                        if32.o_Csr, if32.o_Ecall, if32.o_Ebreak, if32.o_Illegal};
    assign a_ctrl[2] = {ifnw.o_RegWrite, ifnw.o_AluOp_4, ifnw.o_SrcA_PC, ifnw.o_SrcB_Imm,
                        ifnw.o_MemRead, ifnw.o_MemWrite, ifnw.o_MemSize_2, ifnw.o_MemUnsigned,
                        ifnw.o_Branch, ifnw.o_BrCond_3, ifnw.o_Jump, ifnw.o_IsJalr, ifnw.o_WordOp,
                        ifnw.o_Csr, ifnw.o_Ecall, ifnw.o_Ebreak, ifnw.o_Illegal};
    assign a_imm[0] = if64.o_Imm;     assign a_imm[1] = 64'(if32.o_Imm);     assign a_imm[2] = ifnw.o_Imm;
    assign a_pc[0]  = if64.o_PC;      assign a_pc[1]  = 64'(if32.o_PC);      assign a_pc[2]  = ifnw.o_PC;
    assign a_r1[0]  = if64.o_Rs1Data; assign a_r1[1]  = 64'(if32.o_Rs1Data); assign a_r1[2]  = ifnw.o_Rs1Data;
    assign a_r2[0]  = if64.o_Rs2Data; assign a_r2[1]  = 64'(if32.o_Rs2Data); assign a_r2[2]  = ifnw.o_Rs2Data;
    assign a_cd[0]  = if64.o_CSRData; assign a_cd[1]  = 64'(if32.o_CSRData); assign a_cd[2]  = ifnw.o_CSRData;
    assign a_rd[0]  = if64.o_Rd_5;    assign a_rd[1]  = if32.o_Rd_5;         assign a_rd[2]  = ifnw.o_Rd_5;
    assign a_v[0]   = if64.o_Valid;   assign a_v[1]   = if32.o_Valid;        assign a_v[2]   = ifnw.o_Valid;
    assign a_rdy[0] = if64.o_Ready;   assign a_rdy[1] = if32.o_Ready;        assign a_rdy[2] = ifnw.o_Ready;
    assign a_ad1[0] = if64.o_GRFReadAddr1_5; assign a_ad1[1] = if32.o_GRFReadAddr1_5; assign a_ad1[2] = ifnw.o_GRFReadAddr1_5;
    assign a_ad2[0] = if64.o_GRFReadAddr2_5; assign a_ad2[1] = if32.o_GRFReadAddr2_5; assign a_ad2[2] = ifnw.o_GRFReadAddr2_5;
    assign a_cad[0] = if64.o_CSRReadAddr_12; assign a_cad[1] = if32.o_CSRReadAddr_12; assign a_cad[2] = ifnw.o_CSRReadAddr_12;

    typedef struct {
        logic [63:0] imm;
        bit rw, a_pc, b_imm, mr, mw, mu, br, j, jalr, w, csr, ec, eb, ill;
        int alu, msz, brc;
    } exp_t;

    function automatic int xlen_of(input int k);
        return (k == 1) ? 32 : 64;
    endfunction

    function automatic logic [63:0] fit(input logic [63:0] v, input int xl);
        return (xl == 32) ? {32'h0, v[31:0]} : v;
    endfunction

    function automatic logic [22:0] pack(input exp_t e);
        return {e.rw, 4'(e.alu), e.a_pc, e.b_imm, e.mr, e.mw, 2'(e.msz), e.mu, e.br, 3'(e.brc),
                e.j, e.jalr, e.w, e.csr, e.ec, e.eb, e.ill};
    endfunction

    // Instruction-level reference: mnemonic class -> expected bundle
    function automatic exp_t model(input logic [31:0] x, input int xl, input bit enw);
        exp_t e;
        int f3, f7, ar;
        bit rv64, wok, ok;
        int alu_tab [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
        logic [63:0] ii, is, ib, iu, ij;
        e = '{default: 0};
        rv64 = (xl == 64); wok = rv64 && enw;
        f3 = int'(x[14:12]); f7 = int'(x[31:25]);
        ar = alu_tab[f3];
        if (f3 == 5 && x[30]) ar = 7;
        ii = {{52{x[31]}}, x[31:20]};
        is = {{52{x[31]}}, x[31:25], x[11:7]};
        ib = {{51{x[31]}}, x[31], x[7], x[30:25], x[11:8], 1'b0};
        iu = {{32{x[31]}}, x[31:12], 12'h000};
        ij = {{43{x[31]}}, x[31], x[19:12], x[20], x[30:21], 1'b0};
        ok = 1'b1;
        case (x[6:0])
            7'h37: begin e.imm = iu; e.alu = 10; e.b_imm = 1; e.rw = 1; end
            7'h17: begin e.imm = iu; e.a_pc = 1; e.b_imm = 1; e.rw = 1; end
            7'h6F: begin e.imm = ij; e.a_pc = 1; e.b_imm = 1; e.j = 1; e.rw = 1; end
            7'h67: begin e.imm = ii; e.a_pc = 1; e.b_imm = 1; e.j = 1; e.jalr = 1; e.rw = 1; ok = (f3 == 0); end
            7'h63: begin e.imm = ib; e.br = 1; e.brc = f3; ok = !(f3 inside {2, 3}); end
            7'h03: begin
                e.imm = ii; e.b_imm = 1; e.mr = 1; e.rw = 1; e.msz = f3 % 4; e.mu = (f3 >= 4);
                ok = (f3 inside {0, 1, 2, 4, 5}) || (rv64 && (f3 inside {3, 6}));
            end
            7'h23: begin
                e.imm = is; e.b_imm = 1; e.mw = 1; e.msz = f3 % 4;
                ok = (f3 inside {0, 1, 2}) || (rv64 && f3 == 3);
            end
            7'h13: begin
                e.imm = ii; e.b_imm = 1; e.rw = 1; e.alu = ar;
                if (f3 == 1) ok = (x[31:26] == 0) && (rv64 || !x[25]);
                if (f3 == 5) ok = (x[31:26] == 0 || x[31:26] == 6'h10) && (rv64 || !x[25]);
            end
            7'h33: begin
                e.rw = 1; e.alu = (f3 == 0 && x[30]) ? 1 : ar;
                ok = (f7 == 0) || (f7 == 32 && (f3 inside {0, 5}));
            end
            7'h1B: begin
                e.imm = ii; e.b_imm = 1; e.rw = 1; e.w = 1; e.alu = ar;
                ok = wok && ((f3 == 0) || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 inside {0, 32})));
            end
            7'h3B: begin
                e.rw = 1; e.w = 1; e.alu = (f3 == 0 && x[30]) ? 1 : ar;
                ok = wok && (f3 inside {0, 1, 5}) && ((f7 == 0) || (f7 == 32 && f3 != 1));
            end
            7'h0F: begin e.imm = ii; ok = (f3 == 0); end
            7'h73: begin
                e.imm = ii;
                if (f3 == 0) begin
                    e.ec = (x == 32'h73); e.eb = (x == 32'h0010_0073); ok = e.ec || e.eb;
                end else if (f3 == 4) ok = 1'b0;
                else begin e.csr = 1; e.rw = 1; e.brc = f3; end
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e = '{default: 0};
            e.ill = 1;
        end else if (x[11:7] == 0) e.rw = 0;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: handshake is configuration-independent, decode is per instance
    logic        m_valid = 1'b0;
    logic [63:0] m_pc, m_r1, m_r2, m_cd;
    logic [4:0]  m_rd;
    exp_t        m_dec [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_valid <= 1'b0;
        else if (s_flush) m_valid <= 1'b0;
        else if (s_valid && (!m_valid || s_ready)) begin
            m_valid <= 1'b1;
            m_pc <= s_pc; m_r1 <= s_rs1; m_r2 <= s_rs2; m_cd <= s_csr; m_rd <= s_inst[11:7];
            for (int k = 0; k < 3; k++) m_dec[k] <= model(s_inst, xlen_of(k), k != 2);
        end else if (s_ready) m_valid <= 1'b0;
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            int xl;
            xl = xlen_of(k);
            chk($sformatf("d%0d.valid", k), 64'(a_v[k]), 64'(m_valid));
            chk($sformatf("d%0d.ready", k), 64'(a_rdy[k]), 64'(!m_valid || s_ready));
            chk($sformatf("d%0d.raddr", k), {a_ad1[k], a_ad2[k], a_cad[k]},
                {s_inst[19:15], s_inst[24:20], s_inst[31:20]});
            if (m_valid) begin
                chk($sformatf("d%0d.pc", k),   a_pc[k], fit(m_pc, xl));
                chk($sformatf("d%0d.rs1", k),  a_r1[k], fit(m_r1, xl));
                chk($sformatf("d%0d.rs2", k),  a_r2[k], fit(m_r2, xl));
                chk($sformatf("d%0d.csr", k),  a_cd[k], fit(m_cd, xl));
                chk($sformatf("d%0d.rd", k),   64'(a_rd[k]), 64'(m_rd));
                chk($sformatf("d%0d.imm", k),  a_imm[k], fit(m_dec[k].imm, xl));
                chk($sformatf("d%0d.ctrl", k), 64'(a_ctrl[k]), 64'(pack(m_dec[k])));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] inst, input logic [63:0] r1);
        s_valid = 1'b1; s_ready = 1'b1; s_flush = 1'b0; s_inst = inst; s_rs1 = r1;
        step();
        s_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] x;
        logic [6:0]  ops [13] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23,
                                  7'h13, 7'h33, 7'h1B, 7'h3B, 7'h0F, 7'h73};
        x = $urandom;
        case ($urandom_range(0, 3))
            0: x[31:25] = 7'h00;
            1: x[31:25] = 7'h20;
            default: ;
        endcase
        x[6:0] = ops[$urandom_range(0, 12)];
        if ($urandom_range(0, 7) == 0) x = $urandom;
        if ($urandom_range(0, 15) == 0) x = $urandom_range(0, 1) ? 32'h73 : 32'h0010_0073;
        return x;
    endfunction

    initial begin
        repeat (2) @(negedge clk);
        chk("rst.valid", 64'(if64.o_Valid), 64'd0);
        chk("rst.imm", if64.o_Imm, 64'd0);
        chk("rst.regwrite", 64'(if64.o_RegWrite), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        issue(32'hFFF1_0093, 64'd5);
        @(negedge clk);
        chk("addi.valid", 64'(if64.o_Valid), 64'd1);
        chk("addi.imm", if64.o_Imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi.alu", 64'(if64.o_AluOp_4), 64'd0);
        chk("addi.srcb", 64'(if64.o_SrcB_Imm), 64'd1);
        chk("addi.rd", 64'(if64.o_Rd_5), 64'd1);
        chk("addi.rw", 64'(if64.o_RegWrite), 64'd1);
        chk("addi.rs1", if64.o_Rs1Data, 64'd5);

        issue(32'hFE11_2E23, 64'd0);
        @(negedge clk);
        chk("sw.memwrite", 64'(if64.o_MemWrite), 64'd1);
        chk("sw.size", 64'(if64.o_MemSize_2), 64'd2);
        chk("sw.imm", if64.o_Imm, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("sw.rw", 64'(if64.o_RegWrite), 64'd0);

        issue(32'h4020_81B3, 64'd0);
        @(negedge clk);
        chk("sub.alu", 64'(if64.o_AluOp_4), 64'd1);
        chk("sub.rd", 64'(if64.o_Rd_5), 64'd3);

        issue(32'h0010_809B, 64'd0);
        @(negedge clk);
        chk("addiw64.word", 64'(if64.o_WordOp), 64'd1);
        chk("addiw64.ill", 64'(if64.o_Illegal), 64'd0);
        chk("addiw32.ill", 64'(if32.o_Illegal), 64'd1);
        chk("addiw32.rw", 64'(if32.o_RegWrite), 64'd0);
        chk("addiwnw.ill", 64'(ifnw.o_Illegal), 64'd1);
        chk("addiwnw.rw", 64'(ifnw.o_RegWrite), 64'd0);

        issue(32'h0000_0000, 64'd0);
        @(negedge clk);
        chk("zero.ill", 64'(if64.o_Illegal), 64'd1);
        issue(32'h0000_0073, 64'd0);
        @(negedge clk);
        chk("ecall.flag", 64'(if64.o_Ecall), 64'd1);

        // Back-pressure: held bundle stays put while a new one is offered
        issue(32'hFFF1_0093, 64'd5);
        s_ready = 1'b0; s_valid = 1'b1; s_inst = 32'h1234_50B7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp.ready", 64'(if64.o_Ready), 64'd0);
            chk("bp.valid", 64'(if64.o_Valid), 64'd1);
            chk("bp.imm", if64.o_Imm, 64'hFFFF_FFFF_FFFF_FFFF);
            step();
        end
        s_ready = 1'b1;
        step();
        s_valid = 1'b0;
        @(negedge clk);
        chk("bp.new_imm", if64.o_Imm, 64'h0000_0000_1234_5000);
        chk("bp.new_alu", 64'(if64.o_AluOp_4), 64'd10);

        s_valid = 1'b1; s_flush = 1'b1; s_inst = 32'hFFF1_0093;
        step();
        s_valid = 1'b0; s_flush = 1'b0;
        @(negedge clk);
        chk("flush_acc.valid", 64'(if64.o_Valid), 64'd0);

        issue(32'hFFF1_0093, 64'd5);
        s_ready = 1'b0;
        step();
        s_flush = 1'b1;
        step();
        s_flush = 1'b0;
        @(negedge clk);
        chk("flush_stall.valid", 64'(if64.o_Valid), 64'd0);

        // Asynchronous reset in the middle of a stalled cycle
        issue(32'hFFF1_0093, 64'd5);
        s_ready = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", 64'(if64.o_Valid), 64'd0);
        chk("arst.imm", if64.o_Imm, 64'd0);
        chk("arst.rs1", if64.o_Rs1Data, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        issue(32'hFFF1_0093, 64'd7);
        @(negedge clk);
        chk("post_rst.valid", 64'(if64.o_Valid), 64'd1);
        chk("post_rst.imm", if64.o_Imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("post_rst.rs1", if64.o_Rs1Data, 64'd7);

        for (int i = 0; i < 4000; i++) begin
            s_valid = ($urandom_range(0, 9) < 7);
            s_ready = ($urandom_range(0, 9) < 7);
            s_flush = ($urandom_range(0, 19) == 0);
            s_inst  = rand_inst();
            s_pc    = {$urandom, $urandom};
            s_rs1   = {$urandom, $urandom};
            s_rs2   = {$urandom, $urandom};
            s_csr   = {$urandom, $urandom};
            step();
        end
        s_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
